// File: rtl/fu_div_iter_if.sv
// Issue-side handshake bundle for the iterative divide unit: start request,
// operands and mode in one direction, busy/finish/result in the other.
interface fu_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             EN;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             finish;
    logic [WIDTH-1:0] res;

    modport master (
        output EN, op, A, B,
        input  busy, finish, res
    );

    modport slave (
        input  EN, op, A, B,
        output busy, finish, res
    );
endinterface

// File: rtl/fu_div_iter.sv
// Radix-2 restoring integer divider with DIV/DIVU/REM/REMU semantics and a fixed
// WIDTH+2 cycle occupancy (PREP, WIDTH CALC steps, DONE).
module fu_div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    fu_div_iter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [1:0]       op_reg;
    logic [WIDTH-1:0] a_reg;      // original dividend, needed for REM by zero
    logic [WIDTH-1:0] b_reg;      // divisor; holds |B| from PREP onward
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div0_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] res_reg;

    logic             signed_mode;
    logic             is_rem;
    logic             accept;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH+1:0] shift_r;
    logic [WIDTH+1:0] trial;
    logic             sub_ok;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_next;
    logic             busy;
    logic             finish;

    assign signed_mode = ~op_reg[0];
    assign is_rem      = op_reg[1];
    assign accept      = bus.EN && ((state_reg == IDLE) || (state_reg == DONE));

    assign a_abs = (signed_mode && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_abs = (signed_mode && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    // R carries an always-zero top bit; shifting it in keeps the trial's sign bit honest.
    assign shift_r = {r_reg, q_reg[WIDTH-1]};
    assign trial   = shift_r - {2'b00, b_reg};
    assign sub_ok  = ~trial[WIDTH+1];
    assign r_next  = sub_ok ? trial[WIDTH:0] : shift_r[WIDTH:0];
    assign q_next  = {q_reg[WIDTH-2:0], sub_ok};

    assign quot = neg_q_reg ? -q_next : q_next;
    assign rem  = neg_r_reg ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];

    always_comb begin
        res_next = is_rem ? rem : quot;
        if (div0_reg) begin
            res_next = is_rem ? a_reg : {WIDTH{1'b1}};
        end else if (ovf_reg) begin
            res_next = is_rem ? {WIDTH{1'b0}} : MIN_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.EN) state_next = PREP;
            PREP: state_next = CALC;
            CALC: if (cnt_reg == CNT_LAST) state_next = DONE;
            DONE: state_next = bus.EN ? PREP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        finish = 1'b0;
        case (state_reg)
            PREP, CALC: busy   = 1'b1;
            DONE:       finish = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy   = busy;
    assign bus.finish = finish;
    assign bus.res    = res_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_reg    <= 2'b00;
            a_reg     <= '0;
            b_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            div0_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            res_reg   <= '0;
        end else begin
            if (accept) begin
                op_reg <= bus.op;
                a_reg  <= bus.A;
                b_reg  <= bus.B;
            end else if (state_reg == PREP) begin
                q_reg     <= a_abs;
                b_reg     <= b_abs;
                r_reg     <= '0;
                cnt_reg   <= '0;
                neg_r_reg <= signed_mode & a_reg[WIDTH-1];
                neg_q_reg <= signed_mode & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                div0_reg  <= (b_reg == '0);
                ovf_reg   <= signed_mode && (a_reg == MIN_VAL) && (b_reg == {WIDTH{1'b1}});
            end else if (state_reg == CALC) begin
                q_reg   <= q_next;
                r_reg   <= r_next;
                cnt_reg <= cnt_reg + CNT_ONE;
                // Result is captured on the final step so it lines up with finish.
                if (cnt_reg == CNT_LAST) begin
                    res_reg <= res_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_fu_div_iter.sv
// Directed bench for fu_div_iter: an arithmetic reference model plus a per-cycle
// compare of busy/finish/res, and literal expectations for the listed vectors.
module tb_fu_div_iter;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;   // edges from accept edge to the finish cycle

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    int   cyc;

    fu_div_iter_if #(.WIDTH(WIDTH)) bus ();

    fu_div_iter #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: at most one op in flight, finishing LAT edges after its accept edge.
    logic        p_valid;
    int          p_due;
    logic [31:0] p_res;
    logic [31:0] m_res;

    initial begin
        cyc     = 0;
        p_valid = 1'b0;
        p_due   = 0;
        p_res   = '0;
        m_res   = '0;
    end

    always @(posedge clk) begin : ref_model
        int   e;
        logic v;
        e = cyc + 1;
        v = p_valid;
        if (!rstn) begin
            v = 1'b0;
            m_res <= '0;
        end else begin
            if (v && p_due == e) m_res <= p_res;
            if (v && p_due == e - 1) v = 1'b0;
            if (bus.EN && !v) begin
                v = 1'b1;
                p_due <= e + LAT;
                p_res <= model(bus.op, bus.A, bus.B);
            end
        end
        p_valid <= v;
        cyc     <= e;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy",   {31'd0, bus.busy},   {31'd0, p_valid && cyc < p_due});
            check("finish", {31'd0, bus.finish}, {31'd0, p_valid && cyc == p_due});
            check("res",    bus.res, m_res);
        end
    end

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int start;
        int t;
        check({nm, " model"}, model(o, a, b), exp);
        @(negedge clk);
        bus.EN = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(posedge clk);
        #1 start = cyc;
        @(negedge clk);
        bus.EN = 1'b0;
        t = 0;
        while (!bus.finish && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({nm, " timeout"}, {31'd0, bus.finish}, 32'd1);
        check({nm, " res"}, bus.res, exp);
        check({nm, " latency"}, 32'(cyc - start), 32'(LAT));
        $display("[TB] %s op=%0d A=%h B=%h res=%h lat=%0d", nm, o, a, b, bus.res, cyc - start);
    endtask

    initial begin
        int t;
        int nfin;
        int f1;
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        bus.EN  = 1'b0;
        bus.op  = 2'b00;
        bus.A   = '0;
        bus.B   = '0;
        repeat (3) @(negedge clk);
        check("reset busy",   {31'd0, bus.busy},   32'd0);
        check("reset finish", {31'd0, bus.finish}, 32'd0);
        check("reset res",    bus.res,             32'd0);
        rstn = 1'b1;

        run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14);
        run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2);
        run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        run_op("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD);
        run_op("divu_by0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF);
        run_op("rem_by0",      2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB);
        run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
        run_op("divu_ovfops",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);

        // EN held high: garbage operands while busy, a new op launched in the DONE cycle.
        @(negedge clk);
        bus.EN = 1'b1; bus.op = 2'b01; bus.A = 32'd100; bus.B = 32'd7;
        nfin = 0; f1 = 0; t = 0;
        while (nfin < 2 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.finish) begin
                nfin++;
                if (nfin == 1) begin
                    check("held first res", bus.res, 32'd14);
                    f1 = cyc;
                    bus.A = 32'd50; bus.B = 32'd5;
                end else begin
                    check("held second res", bus.res, 32'd10);
                    check("held period", 32'(cyc - f1), 32'(WIDTH + 2));
                    bus.EN = 1'b0;
                end
            end else begin
                bus.A = $urandom;
                bus.B = $urandom;
            end
        end
        bus.EN = 1'b0;
        check("held finishes", 32'(nfin), 32'd2);
        $display("[TB] held_en finishes=%0d res=%h", nfin, bus.res);
        repeat (3) @(negedge clk);

        // Reset mid-operation discards the in-flight op.
        bus.EN = 1'b1; bus.op = 2'b01; bus.A = 32'd1000; bus.B = 32'd3;
        @(negedge clk);
        bus.EN = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midreset busy",   {31'd0, bus.busy},   32'd0);
        check("midreset finish", {31'd0, bus.finish}, 32'd0);
        check("midreset res",    bus.res,             32'd0);
        rstn = 1'b1;
        nfin = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.finish) nfin++;
        end
        check("midreset no finish", 32'(nfin), 32'd0);
        $display("[TB] midreset finishes_after=%0d res=%h", nfin, bus.res);

        run_op("divu_9_3",     2'b01, 32'd9,          32'd3,          32'd3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
